riscv_main_decoder: RTL and testbench
=====================================

# riscv_main_decoder

Main control decoder for the pipelined RV32I core, sitting in the decode stage between the instruction fetch/decode register and the ID/EX pipeline register. It maps the 7-bit instruction opcode to the datapath control bits (ALU operand select, write-back select, register-file write, data-memory read/write, branch, jump) and the 2-bit ALUop consumed by the ALU controller. Outputs are registered, so they align with the decode-to-execute stage boundary. Stall and flush controls are included for hazard handling.

## Interface
Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; clears all output registers
- opcode  input  7  instruction bits [6:0] of the decoded instruction
- stall  input  1  synchronous hold; output registers keep their value
- flush  input  1  synchronous bubble insert; output registers load all-zero (NOP)
- ALUSrc  output  1  1 = ALU operand B is immediate, 0 = rs2
- MemtoReg  output  1  1 = write-back data from data memory, 0 = from ALU/PC path
- RegWrite  output  1  register-file write enable
- MemRead  output  1  data-memory read enable
- MemWrite  output  1  data-memory write enable
- Branch  output  1  conditional branch instruction
- Jump  output  1  JAL/JALR instruction
- ALUop  output  2  00 add (address/pass), 01 branch compare, 10 R-type, 11 I-type ALU
- Illegal  output  1  opcode not in the decode table

## Operation
Combinational decode, result captured into output registers. Decode table (bits listed as ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUop); any bit not listed is 0:
- 0110011 R-type: RegWrite=1, ALUop=10
- 0010011 I-type ALU: ALUSrc=1, RegWrite=1, ALUop=11
- 0000011 load: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUop=00
- 0100011 store: ALUSrc=1, MemWrite=1, ALUop=00
- 1100011 branch: Branch=1, ALUop=01, ALUSrc=0
- 1101111 JAL: RegWrite=1, Jump=1, ALUop=00
- 1100111 JALR: ALUSrc=1, RegWrite=1, Jump=1, ALUop=00
- 0110111 LUI, 0010111 AUIPC: ALUSrc=1, RegWrite=1, ALUop=00
- any other value: all control bits 0, ALUop=00, Illegal=1
- MemRead and MemWrite are never both 1; Branch and Jump are never both 1.
- Priority each edge: reset (async) > flush > stall > normal load.
- Flush loads all outputs 0 including Illegal (bubble is a legal NOP).
- Stall holds every output, including Illegal, unchanged.

## Timing
- Reset asserted (reset=0): all outputs go to 0 immediately, no clock needed; remain 0 until first rising edge after reset=1.
- Latency: 1 cycle; opcode sampled on rising edge N drives outputs after edge N, stable for the whole of cycle N+1.
- No combinational path from opcode, stall or flush to any output.
- flush and stall both high on the same edge: flush wins (outputs zero).
- Reset deasserting with opcode already valid: first decode appears after first rising edge with reset=1.
- X/Z on opcode is not handled; the driver guarantees a valid opcode whenever stall=0 and flush=0.

## Test plan
- Reset: hold reset=0 with opcode=1100011, toggle clk -> all outputs 0, Illegal=0; release, one edge later -> Branch=1, ALUop=01, all others 0.
- Sweep all 9 table opcodes, one per cycle -> each output vector matches its table row exactly one cycle after being applied; Illegal=0 throughout.
- Illegal opcode 1111111 -> all control bits 0, ALUop=00, Illegal=1; then 0110011 -> RegWrite=1, ALUop=10, Illegal=0.
- Stall: load 0000011 (MemRead=1, MemtoReg=1), then stall=1 with opcode=0100011 for 3 edges -> load vector held; stall=0 -> MemWrite=1, ALUSrc=1, MemRead=0.
- Flush: opcode=1101111 with flush=1 and stall=1 -> all outputs 0 after the edge; flush=0 -> Jump=1, RegWrite=1.
- Async reset mid-operation: with JALR outputs active, drop reset between edges -> outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_main_decoder.sv
// rtl/riscv_main_decoder.sv - registered RV32I main control decoder with stall/flush
module riscv_main_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       stall,
    input  logic       flush,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic       Jump,
    output logic [1:0] ALUop,
    output logic       Illegal
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    always_comb begin
        dec_ctrl = '0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b10;
            end
            OP_ITYPE: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b11;
            end
            OP_LOAD: begin
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
            end
            OP_STORE: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = 2'b01;
            end
            OP_JAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
            end
            OP_JALR: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
    end

    // Flush outranks stall so a bubble can be injected into a held slot.
    always_comb begin
        ctrl_d = ctrl_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d = dec_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ALUSrc   = ctrl_q.alu_src;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign Branch   = ctrl_q.branch;
    assign Jump     = ctrl_q.jump;
    assign ALUop    = ctrl_q.alu_op;
    assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_riscv_main_decoder.sv
// tb/tb_riscv_main_decoder.sv - randomized self-checking bench for riscv_main_decoder
module tb_riscv_main_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       stall;
    logic       flush;
    logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, Illegal;
    logic [1:0] ALUop;

    riscv_main_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .stall    (stall),
        .flush    (flush),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .Jump     (Jump),
        .ALUop    (ALUop),
        .Illegal  (Illegal)
    );

    always #5 clk = ~clk;

    // Observed vector order: ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUop[1:0] Illegal
    logic [9:0] obs;
    assign obs = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUop, Illegal};

    logic [6:0] tbl_opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [9:0] tbl_vec [9] = '{10'b0010000100, 10'b1010000110, 10'b1111000000, 10'b1000100000,
                                10'b0000010010, 10'b0010001000, 10'b1010001000, 10'b1010000000,
                                10'b1010000000};

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q  = '0;

    function automatic logic [9:0] ref_decode(input logic [6:0] o);
        for (int i = 0; i < 9; i++) begin
            if (tbl_opc[i] == o) return tbl_vec[i];
        end
        return 10'b0000000001;
    endfunction

    task automatic cyc(input logic [6:0] o, input logic s, input logic f);
        opcode = o;
        stall  = s;
        flush  = f;
        @(posedge clk);
        #1;
        if (!reset)      exp_q = '0;
        else if (f)      exp_q = '0;
        else if (!s)     exp_q = ref_decode(o);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        opcode = 7'b1100011;
        stall  = 1'b0;
        flush  = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL reset_async_start: got %b expected %b", obs, 10'b0);
        end
        cyc(7'b1100011, 1'b0, 1'b0);
        cyc(7'b1100011, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", obs, 10'b0);
        end
        reset = 1'b1;
        cyc(7'b1100011, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b0000010010) begin
            errors++;
            $display("FAIL reset_release_branch: got %b expected %b", obs, 10'b0000010010);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 9; i++) begin
            cyc(tbl_opc[i], 1'b0, 1'b0);
            checks++;
            if (obs !== exp_q || Illegal !== 1'b0) begin
                errors++;
                $display("FAIL sweep_op%b: got %b expected %b", tbl_opc[i], obs, exp_q);
            end
        end
    endtask

    task automatic test_illegal();
        cyc(7'b1111111, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b0000000001) begin
            errors++;
            $display("FAIL illegal_op: got %b expected %b", obs, 10'b0000000001);
        end
        cyc(7'b0110011, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b0010000100) begin
            errors++;
            $display("FAIL illegal_then_rtype: got %b expected %b", obs, 10'b0010000100);
        end
    endtask

    task automatic test_stall();
        cyc(7'b0000011, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b1111000000) begin
            errors++;
            $display("FAIL stall_load: got %b expected %b", obs, 10'b1111000000);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(7'b0100011, 1'b1, 1'b0);
            checks++;
            if (obs !== 10'b1111000000) begin
                errors++;
                $display("FAIL stall_hold%0d: got %b expected %b", i, obs, 10'b1111000000);
            end
        end
        cyc(7'b0100011, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b1000100000) begin
            errors++;
            $display("FAIL stall_release_store: got %b expected %b", obs, 10'b1000100000);
        end
        cyc(7'b1111110, 1'b0, 1'b0);
        cyc(7'b0110011, 1'b1, 1'b0);
        checks++;
        if (obs !== 10'b0000000001) begin
            errors++;
            $display("FAIL stall_hold_illegal: got %b expected %b", obs, 10'b0000000001);
        end
    endtask

    task automatic test_flush();
        cyc(7'b0010011, 1'b0, 1'b0);
        cyc(7'b1101111, 1'b1, 1'b1);
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL flush_over_stall: got %b expected %b", obs, 10'b0);
        end
        cyc(7'b1101111, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b0010001000) begin
            errors++;
            $display("FAIL flush_release_jal: got %b expected %b", obs, 10'b0010001000);
        end
        cyc(7'b0000000, 1'b0, 1'b0);
        cyc(7'b0110011, 1'b0, 1'b1);
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL flush_clears_illegal: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_async_reset();
        cyc(7'b1100111, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b1010001000) begin
            errors++;
            $display("FAIL async_jalr_loaded: got %b expected %b", obs, 10'b1010001000);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_clear: got %b expected %b", obs, 10'b0);
        end
        exp_q = '0;
        cyc(7'b1100111, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(7'b1100111, 1'b0, 1'b0);
        checks++;
        if (obs !== 10'b1010001000) begin
            errors++;
            $display("FAIL async_reset_recover: got %b expected %b", obs, 10'b1010001000);
        end
    endtask

    task automatic test_random();
        logic [6:0] o;
        logic       s;
        logic       f;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) o = 7'($urandom);
            else                        o = tbl_opc[$urandom_range(8)];
            s = ($urandom_range(3) == 0);
            f = ($urandom_range(9) == 0);
            cyc(o, s, f);
            checks++;
            if (obs !== exp_q) begin
                errors++;
                $display("FAIL random%0d op=%b stall=%b flush=%b: got %b expected %b",
                         i, o, s, f, obs, exp_q);
            end
            checks++;
            if ((MemRead && MemWrite) || (Branch && Jump)) begin
                errors++;
                $display("FAIL exclusive%0d: got %b expected no MemRead&MemWrite nor Branch&Jump",
                         i, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_illegal();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
